// File: rtl/pkt_rd_sink.sv
// Byte-stream packet sink: frames packets by sop/eop, accumulates length and checksum,
// flags framing errors and reports one status record per packet.
module pkt_rd_sink #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned MAX_LEN = 1024,
  parameter int unsigned LEN_W   = 11
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_in_valid,
  input  logic [DATA_W-1:0] io_in_data,
  input  logic              io_in_sop,
  input  logic              io_in_eop,
  output logic              io_in_ready,
  input  logic              io_stall,
  output logic              io_stat_valid,
  input  logic              io_stat_ready,
  output logic [LEN_W-1:0]  io_stat_len,
  output logic [15:0]       io_stat_sum,
  output logic [2:0]        io_stat_err,
  output logic [15:0]       io_pkt_cnt,
  output logic [15:0]       io_err_cnt
);

  typedef enum logic [1:0] {StIdle, StBody, StReport} state_e;

  localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] OneLen = LEN_W'(1);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [15:0]      sum_q, sum_d;
  logic [2:0]       err_q, err_d;
  logic             orphan_q, orphan_d;
  logic [15:0]      pkt_cnt_q, pkt_cnt_d;
  logic [15:0]      err_cnt_q, err_cnt_d;
  logic             beat;
  logic [15:0]      data_ext;

  // Ready depends only on state and stall so upstream can never form a comb loop through valid.
  assign io_in_ready = !io_stall && (state_q != StReport);
  assign beat        = io_in_valid && io_in_ready;
  assign data_ext    = 16'(io_in_data);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    sum_d     = sum_q;
    err_d     = err_q;
    orphan_d  = orphan_q;
    pkt_cnt_d = pkt_cnt_q;
    err_cnt_d = err_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (beat) begin
          if (io_in_sop) begin
            len_d    = OneLen;
            sum_d    = data_ext;
            err_d    = {2'b00, orphan_q};
            orphan_d = 1'b0;
            state_d  = io_in_eop ? StReport : StBody;
          end else begin
            orphan_d  = 1'b1;
            err_cnt_d = err_cnt_q + 16'd1;
          end
        end
      end
      StBody: begin
        if (beat) begin
          if (io_in_sop) begin
            // Restart keeps the orphan history but forgets any overlength from the lost body.
            len_d = OneLen;
            sum_d = data_ext;
            err_d = {1'b0, 1'b1, err_q[0]};
          end else begin
            sum_d = sum_q + data_ext;
            if (len_q < MaxLen) begin
              len_d = len_q + OneLen;
            end else begin
              err_d[2] = 1'b1;
            end
          end
          if (io_in_eop) begin
            state_d = StReport;
          end
        end
      end
      StReport: begin
        if (io_stat_ready) begin
          pkt_cnt_d = pkt_cnt_q + 16'd1;
          if (err_q != 3'b000) begin
            err_cnt_d = err_cnt_q + 16'd1;
          end
          len_d   = '0;
          sum_d   = '0;
          err_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      len_q     <= '0;
      sum_q     <= '0;
      err_q     <= '0;
      orphan_q  <= 1'b0;
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      sum_q     <= sum_d;
      err_q     <= err_d;
      orphan_q  <= orphan_d;
      pkt_cnt_q <= pkt_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign io_stat_valid = (state_q == StReport);
  assign io_stat_len   = len_q;
  assign io_stat_sum   = sum_q;
  assign io_stat_err   = err_q;
  assign io_pkt_cnt    = pkt_cnt_q;
  assign io_err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_pkt_rd_sink.sv
// Directed self-checking bench for pkt_rd_sink: framing, errors, backpressure and async reset.
module tb_pkt_rd_sink;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned MAX_LEN = 1024;
  localparam int unsigned LEN_W   = 11;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              io_in_valid = 1'b0;
  logic [DATA_W-1:0] io_in_data = '0;
  logic              io_in_sop = 1'b0;
  logic              io_in_eop = 1'b0;
  logic              io_in_ready;
  logic              io_stall = 1'b0;
  logic              io_stat_valid;
  logic              io_stat_ready = 1'b1;
  logic [LEN_W-1:0]  io_stat_len;
  logic [15:0]       io_stat_sum;
  logic [2:0]        io_stat_err;
  logic [15:0]       io_pkt_cnt;
  logic [15:0]       io_err_cnt;

  int checks = 0;
  int errors = 0;
  bit toggle_en = 1'b0;
  int w;

  pkt_rd_sink #(
    .DATA_W (DATA_W),
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (io_in_valid),
    .io_in_data   (io_in_data),
    .io_in_sop    (io_in_sop),
    .io_in_eop    (io_in_eop),
    .io_in_ready  (io_in_ready),
    .io_stall     (io_stall),
    .io_stat_valid(io_stat_valid),
    .io_stat_ready(io_stat_ready),
    .io_stat_len  (io_stat_len),
    .io_stat_sum  (io_stat_sum),
    .io_stat_err  (io_stat_err),
    .io_pkt_cnt   (io_pkt_cnt),
    .io_err_cnt   (io_err_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One beat: holds the byte until the sink shows ready, returns the number of stalled cycles.
  task automatic send(input logic [7:0] d, input logic s, input logic e, output int waits);
    bit done;
    done  = 1'b0;
    waits = 0;
    io_in_valid = 1'b1;
    io_in_data  = d;
    io_in_sop   = s;
    io_in_eop   = e;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clock);
      if (io_stall) check("stall_rdy", {63'd0, io_in_ready}, 64'd0);
      if (io_in_ready) done = 1'b1;
      else waits++;
      @(posedge clock);
      #1;
    end
    if (!done) check("send_timeout", {63'd0, done}, 64'd1);
    io_in_valid = 1'b0;
    io_in_sop   = 1'b0;
    io_in_eop   = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic check_stat(input string tag, input logic [10:0] len, input logic [15:0] sum,
                            input logic [2:0] err);
    check(tag, {33'd0, io_stat_valid, io_stat_len, io_stat_sum, io_stat_err},
          {33'd0, 1'b1, len, sum, err});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    #12;
    check("rst_valid", {63'd0, io_stat_valid}, 64'd0);
    check("rst_ready", {63'd0, io_in_ready}, 64'd1);
    check("rst_rec", {34'd0, io_stat_len, io_stat_sum, io_stat_err}, 64'd0);
    check("rst_cnts", {32'd0, io_pkt_cnt, io_err_cnt}, 64'd0);
    io_stall = 1'b1;
    #1;
    check("rst_ready_stall", {63'd0, io_in_ready}, 64'd0);
    io_stall = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;

    // Basic packet
    send(8'h00, 1'b1, 1'b0, w);
    send(8'h01, 1'b0, 1'b0, w);
    send(8'h02, 1'b0, 1'b0, w);
    check("basic_pre_eop", {63'd0, io_stat_valid}, 64'd0);
    send(8'h03, 1'b0, 1'b1, w);
    check_stat("basic_rec", 11'd4, 16'h0006, 3'b000);
    idle_cycle();
    check("basic_valid_drop", {63'd0, io_stat_valid}, 64'd0);
    check("basic_cnts", {32'd0, io_pkt_cnt, io_err_cnt}, {32'd0, 16'd1, 16'd0});

    // Single-byte then back-to-back
    send(8'hFF, 1'b1, 1'b1, w);
    check_stat("single_rec", 11'd1, 16'h00FF, 3'b000);
    send(8'h10, 1'b1, 1'b0, w);
    check("b2b_stall", 64'(w), 64'd1);
    send(8'h20, 1'b0, 1'b1, w);
    check_stat("b2b_rec", 11'd2, 16'h0030, 3'b000);
    idle_cycle();
    check("b2b_cnts", {32'd0, io_pkt_cnt, io_err_cnt}, {32'd0, 16'd3, 16'd0});

    // Orphans then a clean packet
    send(8'hAA, 1'b0, 1'b0, w);
    send(8'hBB, 1'b0, 1'b1, w);
    check("orphan_errcnt", 64'(io_err_cnt), 64'd2);
    check("orphan_valid", {63'd0, io_stat_valid}, 64'd0);
    send(8'h01, 1'b1, 1'b0, w);
    send(8'h02, 1'b0, 1'b1, w);
    check_stat("orphan_rec", 11'd2, 16'h0003, 3'b001);
    idle_cycle();
    check("orphan_cnts", {32'd0, io_pkt_cnt, io_err_cnt}, {32'd0, 16'd4, 16'd3});

    // Restart inside a body
    send(8'h05, 1'b1, 1'b0, w);
    send(8'h06, 1'b0, 1'b0, w);
    send(8'h07, 1'b1, 1'b0, w);
    send(8'h08, 1'b0, 1'b1, w);
    check_stat("restart_rec", 11'd2, 16'h000F, 3'b010);
    idle_cycle();
    check("restart_cnts", {32'd0, io_pkt_cnt, io_err_cnt}, {32'd0, 16'd5, 16'd4});

    // Overlong packet: MAX_LEN + 5 bytes of 0x01
    for (int i = 0; i < MAX_LEN + 5; i++) begin
      send(8'h01, (i == 0), (i == MAX_LEN + 4), w);
    end
    check_stat("long_rec", 11'd1024, 16'h0405, 3'b100);
    idle_cycle();
    check("long_cnts", {32'd0, io_pkt_cnt, io_err_cnt}, {32'd0, 16'd6, 16'd5});

    // Backpressure: stall toggling every cycle, consumer not ready for 10 cycles
    io_stat_ready = 1'b0;
    toggle_en = 1'b1;
    fork
      begin
        while (toggle_en) begin
          @(posedge clock);
          #1;
          io_stall = ~io_stall;
        end
      end
    join_none
    send(8'h00, 1'b1, 1'b0, w);
    send(8'h01, 1'b0, 1'b0, w);
    send(8'h02, 1'b0, 1'b0, w);
    send(8'h03, 1'b0, 1'b1, w);
    toggle_en = 1'b0;
    @(posedge clock);
    #2;
    io_stall = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("bp_hold", {30'd0, io_stat_valid, io_in_ready, io_stat_len, io_stat_sum, io_stat_err},
            {30'd0, 1'b1, 1'b0, 11'd4, 16'h0006, 3'b000});
    end
    io_stat_ready = 1'b1;
    idle_cycle();
    check("bp_valid_drop", {63'd0, io_stat_valid}, 64'd0);
    check("bp_cnts", {32'd0, io_pkt_cnt, io_err_cnt}, {32'd0, 16'd7, 16'd5});

    // Asynchronous reset mid-body
    send(8'h11, 1'b1, 1'b0, w);
    send(8'h22, 1'b0, 1'b0, w);
    send(8'h33, 1'b0, 1'b0, w);
    #2;
    reset = 1'b0;
    #1;
    check("arst_rec", {33'd0, io_stat_valid, io_stat_len, io_stat_sum, io_stat_err}, 64'd0);
    check("arst_cnts", {32'd0, io_pkt_cnt, io_err_cnt}, 64'd0);
    check("arst_ready", {63'd0, io_in_ready}, 64'd1);
    @(posedge clock);
    #1;
    reset = 1'b1;
    send(8'h09, 1'b1, 1'b0, w);
    send(8'h01, 1'b0, 1'b1, w);
    check_stat("arst_pkt_rec", 11'd2, 16'h000A, 3'b000);
    idle_cycle();
    check("arst_pkt_cnts", {32'd0, io_pkt_cnt, io_err_cnt}, {32'd0, 16'd1, 16'd0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pkt_rd_sink.md
Name: pkt_rd_sink

Overview:
- Receiving end of the byte-stream packet interface (valid/ready/data/sop/eop) driven by an SRAM controller read port (io_Rd_N_*).
- Accepts bytes under backpressure, frames packets by sop/eop and accumulates length and a 16-bit checksum per packet.
- Detects framing errors and presents one status record per packet on a valid/ready status port.
- Keeps running packet and error counters.
- Serves as the synthesizable sink for controller read ports in block and system benches.

Parameters:
- DATA_W, 8: stream byte width.
- MAX_LEN, 1024: largest legal packet length in bytes.
- LEN_W, 11: width of the length field. Must satisfy 2^LEN_W > MAX_LEN.

Ports:
- clock  in  1  single clock; all state on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- io_in_valid  in  1  input byte valid.
- io_in_data  in  DATA_W  input byte.
- io_in_sop  in  1  first byte of packet.
- io_in_eop  in  1  last byte of packet.
- io_in_ready  out  1  sink can accept a byte this cycle.
- io_stall  in  1  external throttle; forces io_in_ready low.
- io_stat_valid  out  1  status record valid.
- io_stat_ready  in  1  status consumer ready.
- io_stat_len  out  LEN_W  packet length in bytes (sop and eop beats included).
- io_stat_sum  out  16  sum of packet bytes, modulo 2^16.
- io_stat_err  out  3  error flags:
  - bit0: orphan bytes seen before this packet's sop.
  - bit1: packet restarted by sop inside a body.
  - bit2: packet exceeded MAX_LEN.
- io_pkt_cnt  out  16  count of reported packets; wraps.
- io_err_cnt  out  16  count of error events; wraps.

Behaviour:
- Beat: a transfer occurs when io_in_valid && io_in_ready.
- Ready: io_in_ready = !io_stall && state != REPORT. It is combinational from state and io_stall only, never from io_in_valid.
- FSM states: IDLE, BODY, REPORT. Reset state is IDLE.
- Reset values: all outputs 0 except io_in_ready, which equals !io_stall. Internal len, sum, err and pending-orphan flag are 0.
- Reset mid-packet or mid-report discards all state. A status record that has not been accepted is lost.
- IDLE, beat with sop:
  - len=1, sum=data, err={0, 0, orphan_flag}; clear orphan_flag.
  - If eop is also set, go to REPORT; otherwise go to BODY.
- IDLE, beat without sop:
  - Byte dropped; orphan_flag=1; io_err_cnt += 1 per dropped byte.
  - eop on an orphan beat is ignored. Stay in IDLE.
- BODY, beat without sop:
  - sum += data (mod 2^16).
  - If len < MAX_LEN, len += 1. Otherwise len holds at MAX_LEN and err bit2=1.
  - If eop is set, go to REPORT.
- BODY, beat with sop (restart):
  - Discard the accumulated len and sum; len=1, sum=data, err bit1=1.
  - Bit2 is cleared; bit1 is kept until reported.
  - If eop is also set, go to REPORT; otherwise stay in BODY.
- REPORT:
  - io_stat_valid=1, with len/sum/err held stable until io_stat_ready.
  - On the io_stat_valid && io_stat_ready handshake:
    - io_pkt_cnt += 1.
    - io_err_cnt += 1 if err != 0 (one increment per packet, regardless of how many bits are set).
    - Clear the accumulators and go to IDLE.
- Latency:
  - io_stat_valid rises the cycle after the eop beat is accepted.
  - With io_stat_ready held at 1, io_in_ready is low for exactly 1 cycle per packet.
- Simultaneous orphan increment and report increment of io_err_cnt cannot occur, because no beat is accepted in REPORT.
- Counters wrap 0xFFFF→0x0000 without flagging.
- io_stall may toggle on any cycle. A beat is only counted when ready was high in that cycle.

Test Plan:
- Basic packet: bytes 0x00, 0x01, 0x02, 0x03 with sop on 0x00 and eop on 0x03, back-to-back, io_stat_ready=1 → one record with len=4, sum=0x0006, err=0. io_stat_valid is high exactly on the cycle after the eop beat. Afterwards io_pkt_cnt=1, io_err_cnt=0.
- Single-byte and back-to-back: sop+eop byte 0xFF, then immediately a 2-byte packet 0x10, 0x20 → records (len=1, sum=0x00FF) then (len=2, sum=0x0030). The second packet's sop is stalled for the single REPORT cycle.
- Orphans and restart:
  - Bytes 0xAA, 0xBB without sop, then packet 0x01, 0x02 → len=2, sum=0x0003, err=3'b001, io_err_cnt=3 (two orphan bytes plus one errored packet).
  - Then sop 0x05, 0x06, sop 0x07, eop 0x08 → len=2, sum=0x000F, err=3'b010.
- Overlong: a packet of MAX_LEN+5 bytes of 0x01 → len=1024, sum=0x0405, err=3'b100.
- Backpressure:
  - io_stall toggling every other cycle, with io_stat_ready held low for 10 cycles after eop → no beats accepted while io_stall=1.
  - The record stays stable and io_in_ready stays 0 until the handshake. Totals match the basic-packet case.
- Async reset mid-body: after 3 beats, drive reset=0 for 1 cycle → all outputs 0 with no clock edge needed. The next packet 0x09, eop 0x01 reports len=2, sum=0x000A, err=0, pkt_cnt=1.
